// File: rtl/countdown_screen_sequencer.sv
// Pre-game countdown sequencer: steps image_sel through NUM_DIGITS..1, one digit per
// HOLD_FRAMES frames, switching only on the first blanking line so the picture never tears.
module countdown_screen_sequencer #(
    parameter int NUM_DIGITS  = 5,
    parameter int HOLD_FRAMES = 60,
    parameter int V_ACTIVE    = 480
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       start,
    input  logic       skip,
    input  logic       pause,
    output logic [2:0] image_sel,
    output logic       overlay_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [2:0] P_FIRST_DIGIT = 3'(NUM_DIGITS);
    localparam logic [7:0] P_LAST_HOLD   = 8'(HOLD_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
    logic       r_skip_pend;
    logic       w_skip_nxt;
    logic       r_overlay_en;
    logic       w_overlay_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       w_ftick;
    logic       w_advance;

    // One cycle per frame: first pixel of the first blanking line.
    assign w_ftick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_hold_nxt    = r_hold_cnt;
        w_skip_nxt    = r_skip_pend;
        w_overlay_nxt = r_overlay_en;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_advance     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARMED;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_ARMED: begin
                if (w_ftick) begin
                    w_state_nxt   = ST_SHOW;
                    w_sel_nxt     = P_FIRST_DIGIT;
                    w_overlay_nxt = 1'b1;
                    w_hold_nxt    = 8'd0;
                    w_skip_nxt    = 1'b0;
                end
            end

            ST_SHOW: begin
                // A skip arriving on the tick itself is consumed by that tick.
                if (w_ftick) begin
                    if (r_skip_pend || skip) begin
                        w_advance  = 1'b1;
                        w_skip_nxt = 1'b0;
                    end else if (!pause) begin
                        if (r_hold_cnt == P_LAST_HOLD) begin
                            w_advance = 1'b1;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 8'd1;
                        end
                    end
                end else if (skip) begin
                    w_skip_nxt = 1'b1;
                end

                if (w_advance) begin
                    w_hold_nxt = 8'd0;
                    if (r_sel <= 3'd1) begin
                        w_state_nxt   = ST_IDLE;
                        w_sel_nxt     = 3'd0;
                        w_overlay_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_skip_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_sel_nxt = r_sel - 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_sel_nxt     = 3'd0;
                w_hold_nxt    = 8'd0;
                w_skip_nxt    = 1'b0;
                w_overlay_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 3'd0;
            r_hold_cnt   <= 8'd0;
            r_skip_pend  <= 1'b0;
            r_overlay_en <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_skip_pend  <= w_skip_nxt;
            r_overlay_en <= w_overlay_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign image_sel  = r_sel;
    assign overlay_en = r_overlay_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_countdown_screen_sequencer.sv
// Directed bench for countdown_screen_sequencer (NUM_DIGITS=5, HOLD_FRAMES=2); expected
// outputs are queued by the driver and compared by an independent monitor process.
module tb_countdown_screen_sequencer;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       start;
  logic       skip;
  logic       pause;
  logic [2:0] image_sel;
  logic       overlay_en;
  logic       busy;
  logic       done;

  countdown_screen_sequencer #(
    .NUM_DIGITS (5),
    .HOLD_FRAMES(2),
    .V_ACTIVE   (480)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .start     (start),
    .skip      (skip),
    .pause     (pause),
    .image_sel (image_sel),
    .overlay_en(overlay_en),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // scoreboard: {done, busy, overlay_en, image_sel}
  logic [5:0] exp_q[$];
  int         due_q[$];
  string      nm_q[$];
  int         checks = 0;
  int         passed = 0;

  initial begin
    forever begin
      @(posedge vga_clk or negedge reset_n);
      #1;
      while (exp_q.size() > 0 && due_q[0] <= cyc) begin
        logic [5:0] e;
        logic [5:0] got;
        string      nm;
        e   = exp_q.pop_front();
        nm  = nm_q.pop_front();
        void'(due_q.pop_front());
        got = {done, busy, overlay_en, image_sel};
        checks++;
        if (got === e) begin
          passed++;
        end else begin
          $display("FAIL %s @cyc %0d: got done=%0b busy=%0b ov=%0b sel=%0d, want done=%0b busy=%0b ov=%0b sel=%0d",
                   nm, cyc, got[5], got[4], got[3], got[2:0], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input bit ft, input bit st, input bit sk, input bit pa);
    DrawX = ft ? 10'd0 : 10'd5;
    DrawY = ft ? 10'd480 : 10'd100;
    start = st;
    skip  = sk;
    pause = pa;
  endtask

  task automatic expect_o(input string nm, input logic [2:0] sel, input bit ov, input bit bz,
                          input bit dn);
    exp_q.push_back({dn, bz, ov, sel});
    due_q.push_back(cyc + 1);
    nm_q.push_back(nm);
  endtask

  task automatic expect_now(input string nm, input logic [2:0] sel, input bit ov, input bit bz,
                            input bit dn);
    exp_q.push_back({dn, bz, ov, sel});
    due_q.push_back(cyc);
    nm_q.push_back(nm);
  endtask

  task automatic step();
    @(negedge vga_clk);
  endtask

  task automatic cycle_chk(input bit ft, input bit st, input bit sk, input bit pa, input string nm,
                           input logic [2:0] sel, input bit ov, input bit bz, input bit dn);
    drive(ft, st, sk, pa);
    expect_o(nm, sel, ov, bz, dn);
    step();
  endtask

  // stimulus
  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) step();

    // 1: reset state, then start + first tick
    cycle_chk(0, 1, 1, 0, "t1_reset", 3'd0, 0, 0, 0);
    reset_n = 1'b1;
    cycle_chk(0, 0, 0, 0, "t1_idle", 3'd0, 0, 0, 0);
    cycle_chk(0, 1, 0, 0, "t1_armed", 3'd0, 0, 1, 0);
    cycle_chk(0, 0, 0, 0, "t1_armed_wait", 3'd0, 0, 1, 0);
    cycle_chk(1, 0, 0, 0, "t1_show5", 3'd5, 1, 1, 0);

    // 2: free run, each digit held two ticks
    for (int i = 1; i <= 10; i++) begin
      cycle_chk(0, 0, 0, 0, "t2_between", 3'(5 - (i - 1) / 2), 1, 1, 0);
      if (i < 10) cycle_chk(1, 0, 0, 0, "t2_tick", 3'(5 - i / 2), 1, 1, 0);
      else        cycle_chk(1, 0, 0, 0, "t2_done", 3'd0, 0, 0, 1);
    end
    cycle_chk(0, 0, 0, 0, "t2_after_done", 3'd0, 0, 0, 0);

    // 3: skip at sel=4, hold=0; a second skip adds nothing
    cycle_chk(0, 1, 0, 0, "t3_start", 3'd0, 0, 1, 0);
    cycle_chk(1, 0, 0, 0, "t3_show5", 3'd5, 1, 1, 0);
    cycle_chk(1, 0, 0, 0, "t3_hold5", 3'd5, 1, 1, 0);
    cycle_chk(1, 0, 0, 0, "t3_sel4", 3'd4, 1, 1, 0);
    cycle_chk(0, 0, 1, 0, "t3_skip1", 3'd4, 1, 1, 0);
    cycle_chk(0, 0, 0, 0, "t3_gap", 3'd4, 1, 1, 0);
    cycle_chk(0, 0, 1, 0, "t3_skip2", 3'd4, 1, 1, 0);
    cycle_chk(1, 0, 0, 0, "t3_sel3", 3'd3, 1, 1, 0);

    // 4: pause freezes sel=3 (a leftover skip would advance here), then resumes
    for (int i = 0; i < 5; i++) begin
      cycle_chk(0, 0, 0, 1, "t4_gap", 3'd3, 1, 1, 0);
      cycle_chk(1, 0, 0, 1, "t4_paused", 3'd3, 1, 1, 0);
    end
    cycle_chk(1, 0, 0, 0, "t4_resume1", 3'd3, 1, 1, 0);
    cycle_chk(1, 0, 0, 0, "t4_sel2", 3'd2, 1, 1, 0);

    // 5: asynchronous reset mid-cycle at sel=2
    drive(0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    expect_now("t5_async", 3'd0, 0, 0, 0);
    step();
    cycle_chk(1, 0, 0, 0, "t5_in_reset", 3'd0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_chk(1, 0, 0, 0, "t5_idle_tick", 3'd0, 0, 0, 0);
      cycle_chk(0, 0, 0, 0, "t5_idle_gap", 3'd0, 0, 0, 0);
    end

    // 6: skip in ARMED ignored, blanking line scan, start in SHOW, restart in done cycle
    cycle_chk(0, 1, 0, 0, "t6_start", 3'd0, 0, 1, 0);
    cycle_chk(0, 0, 1, 0, "t6_armed_skip", 3'd0, 0, 1, 0);
    cycle_chk(1, 0, 0, 0, "t6_show5", 3'd5, 1, 1, 0);
    cycle_chk(1, 0, 0, 0, "t6_no_pend", 3'd5, 1, 1, 0);
    for (int x = 1; x <= 639; x++) begin
      drive(0, (x % 7) == 0, 0, 0);
      DrawX = 10'(x);
      DrawY = 10'd480;
      expect_o("t6_scan", 3'd5, 1, 1, 0);
      step();
    end
    cycle_chk(1, 0, 0, 0, "t6_sel4", 3'd4, 1, 1, 0);
    cycle_chk(1, 0, 1, 0, "t6_skiptick3", 3'd3, 1, 1, 0);
    cycle_chk(1, 0, 1, 0, "t6_skiptick2", 3'd2, 1, 1, 0);
    cycle_chk(1, 0, 1, 0, "t6_skiptick1", 3'd1, 1, 1, 0);
    cycle_chk(1, 0, 1, 0, "t6_done", 3'd0, 0, 0, 1);
    cycle_chk(0, 1, 0, 0, "t6_restart", 3'd0, 0, 1, 0);
    cycle_chk(1, 0, 0, 0, "t6_reshow", 3'd5, 1, 1, 0);

    // drain and report
    drive(0, 0, 0, 0);
    repeat (3) step();
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
